// File: rtl/craft_pkg.sv
// Shared CRAFT-64 definitions: S-box, nibble permutations, round constants
// and tweakey derivation, used by both the encryptor and the decryptor.
package craft_pkg;

    localparam int unsigned N_ROUNDS = 32;
    localparam int unsigned BLK_W    = 64;
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned RC_W     = 8;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned N_NIB    = 16;

    typedef logic [BLK_W-1:0] block_t;
    typedef block_t [3:0]     tk_set_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] SBOX [N_NIB] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    // Forward permutation moves nibble i to position P[i].
    localparam logic [3:0] P [N_NIB] = '{
        4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
        4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
    };

    localparam logic [3:0] P_INV [N_NIB] = '{
        4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
        4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
    };

    // Tweak permutation: nibble i of Q(T) is nibble Q[i] of T.
    localparam logic [3:0] Q [N_NIB] = '{
        4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
        4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1, 4'd13
    };

    localparam logic [RC_W-1:0] RC [N_ROUNDS] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
        8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
        8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
    };

    // TK0=K0^T, TK1=K1^T, TK2=K0^Q(T), TK3=K1^Q(T).
    function automatic tk_set_t derive_tk(input logic [KEY_W-1:0] key, input block_t tweak);
        block_t  qt;
        tk_set_t tk;
        qt = '0;
        for (int i = 0; i < N_NIB; i++) begin
            qt[4*(15-i) +: 4] = tweak[4*(15-int'(Q[i])) +: 4];
        end
        tk[0] = key[KEY_W-1:BLK_W] ^ tweak;
        tk[1] = key[BLK_W-1:0]     ^ tweak;
        tk[2] = key[KEY_W-1:BLK_W] ^ qt;
        tk[3] = key[BLK_W-1:0]     ^ qt;
        return tk;
    endfunction

endpackage

// File: rtl/craft_inv_round.sv
// One combinational CRAFT-64 inverse round: SB, P^-1 (skipped on the last
// round), tweakey and round-constant addition, then the involutory MixColumn.
module craft_inv_round
    import craft_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    input  logic [BLK_W-1:0] tk,
    input  logic [RC_W-1:0]  rc,
    input  logic             last,
    output logic [BLK_W-1:0] dout
);

    logic [3:0]       sb [N_NIB];
    logic [3:0]       pn [N_NIB];
    logic [BLK_W-1:0] sp;
    logic [BLK_W-1:0] ak;

    // Nibble 0 is the most significant nibble of the block.
    always_comb begin
        sb = '{default: 4'h0};
        pn = '{default: 4'h0};
        sp = '0;
        for (int i = 0; i < N_NIB; i++) begin
            sb[i] = SBOX[din[4*(15-i) +: 4]];
        end
        for (int i = 0; i < N_NIB; i++) begin
            pn[P_INV[i]] = sb[i];
        end
        for (int i = 0; i < N_NIB; i++) begin
            sp[4*(15-i) +: 4] = pn[i];
        end
    end

    // Round constant lands on nibbles 4 and 5.
    assign ak = (last ? din : sp) ^ tk ^ {16'h0, rc, 40'h0};

    assign dout = {ak[63:48] ^ ak[31:16] ^ ak[15:0],
                   ak[47:32] ^ ak[15:0],
                   ak[31:0]};

endmodule

// File: rtl/craft_decrypt.sv
// Iterative CRAFT-64 decryptor: 32 inverse rounds at UNROLL rounds per clock,
// start/busy/done handshake with a held plaintext register.
module craft_decrypt #(
    parameter int unsigned UNROLL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  ciphertext,
    input  logic [63:0]  tweak,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [63:0]  plaintext
);

    import craft_pkg::*;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    block_t           data_q, data_n;
    tk_set_t          tk_q, tk_n;
    logic             busy_n, done_n;
    block_t           pt_n;

    block_t chain [UNROLL+1];

    assign chain[0] = data_q;

    // Round indices handled this clock are idx, idx-1, ... idx-UNROLL+1.
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [IDX_W-1:0] ridx;
        assign ridx = idx_q - IDX_W'(k);

        craft_inv_round u_round (
            .din  (chain[k]),
            .tk   (tk_q[ridx[1:0]]),
            .rc   (RC[ridx]),
            .last (ridx == IDX_W'(N_ROUNDS-1)),
            .dout (chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            tk_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            plaintext <= '0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            data_q    <= data_n;
            tk_q      <= tk_n;
            busy      <= busy_n;
            done      <= done_n;
            plaintext <= pt_n;
        end
    end

    // Plaintext and done update together so the result changes only on done.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        data_n  = data_q;
        tk_n    = tk_q;
        busy_n  = (state_q == ST_RUN);
        done_n  = (state_q == ST_FIN);
        pt_n    = plaintext;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_n  = ciphertext;
                    tk_n    = derive_tk(key, tweak);
                    idx_n   = IDX_W'(N_ROUNDS-1);
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                data_n = chain[UNROLL];
                if (idx_q < IDX_W'(UNROLL)) begin
                    idx_n   = '0;
                    state_n = ST_FIN;
                end else begin
                    idx_n = idx_q - IDX_W'(UNROLL);
                end
            end
            ST_FIN: begin
                pt_n    = data_q;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_craft_decrypt.sv
// Randomized scoreboard bench for craft_decrypt against a nibble-level CRAFT model.
module tb_craft_decrypt;

    logic         clk = 1'b0;
    logic         rst, start, start1;
    logic [63:0]  ciphertext, tweak;
    logic [127:0] key;
    logic         busy, done, busy1, done1;
    logic [63:0]  plaintext, plaintext1;

    always #5 clk = ~clk;

    craft_decrypt #(.UNROLL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext),
        .tweak(tweak), .key(key), .busy(busy), .done(done), .plaintext(plaintext)
    );

    craft_decrypt #(.UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ciphertext(ciphertext),
        .tweak(tweak), .key(key), .busy(busy1), .done(done1), .plaintext(plaintext1)
    );

    localparam logic [63:0]  KV_PT  = 64'h5734f006d8d88a3e;
    localparam logic [127:0] KV_KEY = 128'h27a6781a43f364bc916708d5fbb5aeac;
    localparam logic [63:0]  KV_TW  = 64'h54cd94ffd0670a58;

    int m_sbox [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    int m_p    [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    int m_q    [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    logic [63:0] exp_q [$];
    logic [63:0] exp1_q [$];
    int n_vec = 0, n_err = 0, done_cnt = 0, done1_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] nib(input logic [63:0] x, input int n);
        return x[60-4*n +: 4];
    endfunction

    function automatic logic [63:0] setnib(input logic [63:0] x, input int n, input logic [3:0] v);
        logic [63:0] y;
        y = x;
        y[60-4*n +: 4] = v;
        return y;
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y = setnib(y, i, 4'(m_sbox[nib(x, i)]));
        return y;
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y = setnib(y, m_p[i], nib(x, i));
        return y;
    endfunction

    function automatic logic [63:0] m_unperm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y = setnib(y, i, nib(x, m_p[i]));
        return y;
    endfunction

    function automatic logic [63:0] m_mix(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        for (int j = 0; j < 4; j++) begin
            y = setnib(y, j, nib(x, j) ^ nib(x, j+8) ^ nib(x, j+12));
            y = setnib(y, 4+j, nib(x, 4+j) ^ nib(x, 12+j));
        end
        return y;
    endfunction

    // Round constants regenerated from the 4-bit and 3-bit LFSRs.
    function automatic logic [7:0] m_rc(input int i);
        int a = 1, b = 1;
        for (int r = 0; r < i; r++) begin
            a = (a >> 1) | (((a ^ (a >> 1)) & 1) << 3);
            b = (b >> 1) | (((b ^ (b >> 1)) & 1) << 2);
        end
        return {4'(a), 4'(b)};
    endfunction

    function automatic logic [63:0] m_add_rc(input logic [63:0] x, input int i);
        logic [7:0] rc;
        rc = m_rc(i);
        return setnib(setnib(x, 4, nib(x, 4) ^ rc[7:4]), 5, nib(x, 5) ^ rc[3:0]);
    endfunction

    function automatic logic [63:0] m_tk(input logic [127:0] k, input logic [63:0] t, input int j);
        logic [63:0] qt;
        qt = '0;
        for (int i = 0; i < 16; i++) qt = setnib(qt, i, nib(t, m_q[i]));
        return ((j % 2 == 0) ? k[127:64] : k[63:0]) ^ ((j < 2) ? t : qt);
    endfunction

    function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [127:0] k, input logic [63:0] t);
        logic [63:0] s;
        s = pt;
        for (int i = 0; i < 32; i++) begin
            s = m_add_rc(m_mix(s), i) ^ m_tk(k, t, i % 4);
            if (i < 31) s = m_sub(m_perm(s));
        end
        return s;
    endfunction

    function automatic logic [63:0] model_dec(input logic [63:0] ct, input logic [127:0] k, input logic [63:0] t);
        logic [63:0] s;
        s = ct;
        for (int i = 31; i >= 0; i--) begin
            if (i < 31) s = m_unperm(m_sub(s));
            s = m_mix(m_add_rc(s ^ m_tk(k, t, i % 4), i));
        end
        return s;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: plaintext %h, no result expected", plaintext);
            end else begin
                check("plaintext", plaintext, exp_q.pop_front());
            end
        end
        if (done1 === 1'b1) begin
            done1_cnt++;
            if (exp1_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done_u1: plaintext %h, no result expected", plaintext1);
            end else begin
                check("plaintext_u1", plaintext1, exp1_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done after %0d cycles, required at 17", lat);
        end
    endtask

    // Called just after a rising edge; returns in the cycle done is high.
    task automatic run_op(input logic [63:0] ct, input logic [127:0] k,
                          input logic [63:0] t, input logic [63:0] expv);
        int lat;
        ciphertext = ct; key = k; tweak = t; start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("latency", 64'(lat), 64'd17);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [63:0]  pt, ct, t, first;
        logic [127:0] k;
        int           base, lat;

        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        ciphertext = '0; tweak = '0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_plaintext", plaintext, 64'd0);
        check("reset_busy_u1", 64'(busy1), 64'd0);
        check("reset_plaintext_u1", plaintext1, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known vector with exact handshake timing.
        ciphertext = model_enc(KV_PT, KV_KEY, KV_TW); key = KV_KEY; tweak = KV_TW;
        start = 1'b1;
        exp_q.push_back(KV_PT);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            check("kv_busy", 64'(busy), 64'(c <= 16));
            check("kv_done", 64'(done), 64'(c == 17));
        end

        // Same vector on the single-round-per-clock build.
        start1 = 1'b1;
        exp1_q.push_back(KV_PT);
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            check("u1_busy", 64'(busy1), 64'(c <= 32));
            check("u1_done", 64'(done1), 64'(c == 33));
        end

        // Random round-trip sweep, issued back to back; some raw ciphertexts.
        base = done_cnt;
        for (int n = 0; n < 1000; n++) begin
            pt = rand64(); k = {rand64(), rand64()}; t = rand64();
            if (n % 8 == 7) begin
                ct = rand64();
                run_op(ct, k, t, model_dec(ct, k, t));
            end else begin
                run_op(model_enc(pt, k, t), k, t, pt);
            end
        end
        @(posedge clk); #1;
        check("sweep_done_count", 64'(done_cnt - base), 64'd1000);

        // Start held mid-run with different inputs must be ignored.
        base = done_cnt;
        pt = rand64(); k = {rand64(), rand64()}; t = rand64();
        ct = model_enc(pt, k, t);
        ciphertext = ct; key = k; tweak = t; start = 1'b1;
        exp_q.push_back(pt);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ciphertext = ~ct; key = ~k; tweak = ~t; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
        check("ignored_start_done_count", 64'(done_cnt - base), 64'd1);

        // Reset in the middle of a run.
        pt = rand64(); k = {rand64(), rand64()}; t = rand64();
        ciphertext = model_enc(pt, k, t); key = k; tweak = t; start = 1'b1;
        exp_q.push_back(pt);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_plaintext", plaintext, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        base = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - base), 64'd0);
        run_op(model_enc(KV_PT, KV_KEY, KV_TW), KV_KEY, KV_TW, KV_PT);

        // Back-to-back start the cycle after done, all-zero operands.
        pt = rand64(); k = {rand64(), rand64()}; t = rand64();
        run_op(model_enc(pt, k, t), k, t, pt);
        first = pt;
        ciphertext = '0; key = '0; tweak = '0; start = 1'b1;
        exp_q.push_back(model_dec(64'd0, 128'd0, 64'd0));
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            check("b2b_hold", plaintext, first);
        end
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd1);
        @(posedge clk); #1;

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("queue_empty_u1", 64'(exp1_q.size()), 64'd0);
        check("u1_done_count", 64'(done1_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
